fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Parametrised fetch-PC generator for the pipelined core front end, the successor to the single-width PC register. Each cycle it presents the current fetch-group address to the instruction-fetch stage over a valid/ready handshake. It applies prioritised backend redirects even while stalled, and follows predictor targets. It also aligns multi-instruction fetch groups, tags every request with a redirect epoch for stale-response squashing, and supports a halt/resume mode.

## Interface
- XLEN, 32, address width.
- RESET_PC, 32'h6000_0000, PC after reset; must be 4-byte aligned.
- FETCH_WIDTH, 1, instructions per fetch group; legal values are 1, 2, 4.
- NUM_REDIRECT, 2, number of backend redirect ports; index 0 has highest priority.
- EPOCH_BITS, 2, width of the epoch tag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- redirect_valid  in  NUM_REDIRECT  per-port redirect request (e.g. trap, mispredict).
- redirect_pc  in  NUM_REDIRECT*XLEN  per-port target; port i occupies bits [i*XLEN +: XLEN].
- pred_valid  in  1  predictor says the current group is taken.
- pred_pc  in  XLEN  predictor target.
- halt  in  1  stop fetching after the current cycle.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  fetch stage accepts the request.
- req_pc  out  XLEN  exact fetch PC (current pc register).
- req_slot_mask  out  FETCH_WIDTH  valid instruction slots in the group.
- req_epoch  out  EPOCH_BITS  current epoch.
- pc_prev  out  XLEN  PC of the most recently accepted request.

## Operation
- Definitions:
  - OFF = log2(FETCH_WIDTH)+2.
  - fire = req_valid & req_ready.
  - redir = OR of redirect_valid.
  - sel = lowest index i with redirect_valid[i] set.
  - tgt = redirect_pc[sel] with bits [1:0] forced to 0.
- FSM states:
  - BOOT: req_valid=0. Always moves to RUN at the next edge unless rst is high.
  - RUN: req_valid=1.
  - HALTED: req_valid=0.
- Next-PC priority, evaluated every cycle in RUN or HALTED:
  1. If redir: pc<=tgt and epoch<=epoch+1 (wraps modulo 2^EPOCH_BITS). Applies regardless of req_ready. State becomes RUN, even from HALTED and even if halt is high.
  2. Else, in RUN with fire and pred_valid: pc<=pred_pc with bits [1:0] cleared. Epoch is unchanged.
  3. Else, in RUN with fire: pc<=(pc with bits [OFF-1:0] cleared)+FETCH_WIDTH*4, computed modulo 2^XLEN. The sequential path always moves to the next aligned group.
  4. Else: hold pc.
- pc_prev<=pc whenever fire, including cycles where a redirect also occurs. It is unchanged otherwise.
- In RUN, if halt is high and redir is low, the state moves to HALTED at the edge. A fire in that same cycle still advances pc per rules 2/3.
- In HALTED, pred_valid and halt are ignored. Only a redirect leaves HALTED.
- req_slot_mask[i] = (i >= pc[OFF-1:2]). For FETCH_WIDTH=1 it is constant 1.
- req_pc, req_slot_mask and req_epoch are driven directly from registers and state, with no combinational path from inputs.

## Timing
- Reset values (the cycle after a rst edge):
  - state = BOOT, req_valid = 0.
  - pc = RESET_PC, pc_prev = RESET_PC, epoch = 0.
  - req_slot_mask = mask of RESET_PC.
- req_valid first rises one cycle after the first edge with rst low.
- Redirect latency: redirect_valid at edge N makes req_pc = target and req_epoch incremented in cycle N+1.
- Handshake: while req_valid=1 and req_ready=0, req_pc, req_slot_mask and req_epoch hold stable unless a redirect occurs.
  - A redirect may change the request without acceptance; the consumer must not assume stability across redirects.
- Simultaneous events:
  - Multiple redirect ports: the lowest index wins. Epoch increments by exactly 1.
  - Redirect with pred_valid and fire: the redirect wins and pc_prev still updates.
  - Redirect with halt: the redirect wins and the state stays or becomes RUN.
- Reset mid-operation (any state, any pending stall): returns to reset values at the next edge. The epoch restarts at 0.
- PC wrap-around: 32'hFFFF_FFFC + 4 -> 0, with no flag.

## Test plan
- Reset with FETCH_WIDTH=1: hold rst for 3 cycles, then release.
  - -> req_valid=0 during reset and in BOOT; req_valid=1 with req_pc=6000_0000 on the second cycle after release.
  - -> With req_ready=1, req_pc steps by 4 each cycle and pc_prev lags by one.
- FETCH_WIDTH=4: redirect to 6000_0108, then stream with req_ready=1.
  - -> req_pc=6000_0108 with mask 4'b1100, then 6000_0110 with 4'b1111, then 6000_0120.
- Stall plus redirect: req_ready=0 for 4 cycles; in cycle 2, redirect_valid[1] to 6000_0400.
  - -> req_pc changes to 6000_0400 and epoch goes 0->1 while stalled; pc_prev unchanged.
- Priority: redirect_valid=2'b11 with targets 6000_0800 (port 0) and 6000_0900 (port 1), plus pred_valid.
  - -> req_pc=6000_0800; epoch increments by exactly 1.
- Halt/resume: halt with fire at pc=6000_0010.
  - -> Next cycle is HALTED with req_valid=0 and pc=6000_0014.
  - -> Predictor input is ignored while halted.
  - -> A redirect to 6000_0200 gives req_valid=1 with req_pc=6000_0200 the next cycle.
- Epoch wrap and reset: 5 redirects with EPOCH_BITS=2 give the epoch sequence 1, 2, 3, 0, 1; then assert rst.
  - -> epoch=0 and pc=6000_0000.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// Fetch request bus between the PC generator and the instruction-fetch stage.
// Latency: n/a (wires only).
// Backpressure: req_ready from the fetch stage stalls the request held on req_pc/req_slot_mask/req_epoch.
//
// Signals:
//   req_valid      fetch request valid (generator -> fetch)
//   req_ready      fetch stage accepts the request (fetch -> generator)
//   req_pc         exact fetch PC of the group
//   req_slot_mask  valid instruction slots within the aligned group
//   req_epoch      redirect epoch tag used to squash stale responses
interface fetch_pc_gen_if #(
  parameter int XLEN        = 32,
  parameter int FETCH_WIDTH = 1,
  parameter int EPOCH_BITS  = 2
);
  logic                   req_valid;
  logic                   req_ready;
  logic [XLEN-1:0]        req_pc;
  logic [FETCH_WIDTH-1:0] req_slot_mask;
  logic [EPOCH_BITS-1:0]  req_epoch;

  // Generator side.
  modport master (
    output req_valid,
    input  req_ready,
    output req_pc,
    output req_slot_mask,
    output req_epoch
  );

  // Fetch-stage side.
  modport slave (
    input  req_valid,
    output req_ready,
    input  req_pc,
    input  req_slot_mask,
    input  req_epoch
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: presents aligned fetch groups, follows predictor targets, applies prioritised redirects.
// Latency: one cycle from redirect/predict/accept to the new req_pc; all request outputs come straight from registers.
// Backpressure: request held stable while req_ready is low; redirects still take effect during a stall.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   redirect_valid  per-port backend redirect request, index 0 highest priority
//   redirect_pc     per-port redirect target, port i at [i*XLEN +: XLEN]
//   pred_valid      predictor says the current group is taken
//   pred_pc         predictor target
//   halt            stop fetching after the current cycle (only a redirect resumes)
//   fetch           request bus to the fetch stage (master side)
//   pc_prev         PC of the most recently accepted request
module fetch_pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = 32'h6000_0000,
  parameter int              FETCH_WIDTH  = 1,
  parameter int              NUM_REDIRECT = 2,
  parameter int              EPOCH_BITS   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REDIRECT-1:0]      redirect_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0] redirect_pc,
  input  logic                         pred_valid,
  input  logic [XLEN-1:0]              pred_pc,
  input  logic                         halt,
  fetch_pc_gen_if.master               fetch,
  output logic [XLEN-1:0]              pc_prev
);

  // Byte offset bits covered by one fetch group, and the slot-index width within it.
  localparam int OFF   = $clog2(FETCH_WIDTH) + 2;
  localparam int IDX_W = OFF - 2;

  // Instruction addresses are always word aligned.
  localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] GROUP_MASK = ~XLEN'((1 << OFF) - 1);
  localparam logic [XLEN-1:0] GROUP_STEP = XLEN'(FETCH_WIDTH * 4);
  localparam logic [XLEN-1:0] RESET_PC_W = RESET_PC & WORD_MASK;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       pc_prev_q, pc_prev_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;

  logic                  req_valid;
  logic                  fire;
  logic                  redir;
  logic [XLEN-1:0]       redir_tgt;
  logic [XLEN-1:0]       pred_tgt;
  logic [XLEN-1:0]       seq_pc;
  logic [FETCH_WIDTH-1:0] slot_mask;

  assign req_valid = (state_q == ST_RUN);
  assign fire      = req_valid & fetch.req_ready;
  assign redir     = |redirect_valid;

  // Walk from the highest index down so the lowest active port is the last
  // assignment and therefore wins.
  always_comb begin
    redir_tgt = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        redir_tgt = redirect_pc[i*XLEN +: XLEN];
      end
    end
    redir_tgt = redir_tgt & WORD_MASK;
  end

  assign pred_tgt = pred_pc & WORD_MASK;

  // The sequential path restarts at the next aligned group even when the
  // current PC entered mid-group (after a redirect or a taken prediction).
  // Wraps silently at the top of the address space.
  assign seq_pc = (pc_q & GROUP_MASK) + GROUP_STEP;

  // Slots below the entry offset belong to instructions before the target.
  if (FETCH_WIDTH == 1) begin : g_mask_single
    assign slot_mask = 1'b1;
  end else begin : g_mask_multi
    logic [IDX_W-1:0] slot_idx;
    assign slot_idx = pc_q[OFF-1:2];
    always_comb begin
      slot_mask = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        slot_mask[i] = (IDX_W'(i) >= slot_idx);
      end
    end
  end

  // Next-state / next-PC selection.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epoch_d   = epoch_q;
    pc_prev_d = pc_prev_q;

    // Acceptance records the group even when a redirect replaces the next PC.
    if (fire) begin
      pc_prev_d = pc_q;
    end

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redir) begin
          // Redirect overrides prediction, acceptance and halt.
          pc_d    = redir_tgt;
          epoch_d = epoch_q + EPOCH_BITS'(1);
        end else begin
          if (fire) begin
            pc_d = pred_valid ? pred_tgt : seq_pc;
          end
          if (halt) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        // Prediction and halt are meaningless here; only a redirect resumes.
        if (redir) begin
          pc_d    = redir_tgt;
          epoch_d = epoch_q + EPOCH_BITS'(1);
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC_W;
      pc_prev_q <= RESET_PC_W;
      epoch_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_prev_q <= pc_prev_d;
      epoch_q   <= epoch_d;
    end
  end

  assign fetch.req_valid     = req_valid;
  assign fetch.req_pc        = pc_q;
  assign fetch.req_slot_mask = slot_mask;
  assign fetch.req_epoch     = epoch_q;
  assign pc_prev             = pc_prev_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  redirect_valid;
  logic [63:0] redirect_pc;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        halt;
  logic        ready;
  logic [31:0] pc_prev1, pc_prev4;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_gen_if #(.XLEN(32), .FETCH_WIDTH(1), .EPOCH_BITS(2)) if1 ();
  fetch_pc_gen_if #(.XLEN(32), .FETCH_WIDTH(4), .EPOCH_BITS(2)) if4 ();

  assign if1.req_ready = ready;
  assign if4.req_ready = ready;

  fetch_pc_gen #(
    .XLEN(32), .RESET_PC(32'h6000_0000), .FETCH_WIDTH(1), .NUM_REDIRECT(2), .EPOCH_BITS(2)
  ) dut1 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .halt(halt), .fetch(if1.master), .pc_prev(pc_prev1)
  );

  fetch_pc_gen #(
    .XLEN(32), .RESET_PC(32'h6000_0000), .FETCH_WIDTH(4), .NUM_REDIRECT(2), .EPOCH_BITS(2)
  ) dut4 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .halt(halt), .fetch(if4.master), .pc_prev(pc_prev4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [31:0] rpc0;
    logic [31:0] rpc1;
    logic        pv;
    logic [31:0] ppc;
    logic        halt;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_prev;
    logic [1:0]  exp_epoch;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] rv, logic [31:0] rpc0, logic [31:0] rpc1,
                              logic pv, logic [31:0] ppc, logic h, logic rdy,
                              logic ev, logic [31:0] epc, logic [31:0] eprev, logic [1:0] eep);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc0 = rpc0; v.rpc1 = rpc1; v.pv = pv; v.ppc = ppc;
    v.halt = h; v.ready = rdy; v.exp_valid = ev; v.exp_pc = epc; v.exp_prev = eprev;
    v.exp_epoch = eep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] rv, input logic [31:0] rpc0,
                       input logic [31:0] rpc1, input logic pv, input logic [31:0] ppc,
                       input logic h, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = {rpc1, rpc0};
    pred_valid     = pv;
    pred_pc        = ppc;
    halt           = h;
    ready          = rdy;
  endtask

  initial begin
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Width-1 flow: each row is driven, one edge passes, then outputs are compared.
    //              rst   rv     rpc0           rpc1           pv    ppc            halt  rdy   valid pc             prev           ep
    vecs.push_back(mk(1'b1, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h6000_0000, 32'h6000_0000, 2'd0));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h6000_0000, 32'h6000_0000, 2'd0));
    vecs.push_back(mk(1'b1, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h6000_0000, 32'h6000_0000, 2'd0));
    // release: BOOT -> RUN, no acceptance possible during BOOT
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h6000_0000, 32'h6000_0000, 2'd0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h6000_0004, 32'h6000_0000, 2'd0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h6000_0008, 32'h6000_0004, 2'd0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h6000_000C, 32'h6000_0008, 2'd0));
    // stall, redirect on port 1 while stalled
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h6000_000C, 32'h6000_0008, 2'd0));
    vecs.push_back(mk(1'b0, 2'b10, 32'h0,         32'h6000_0400, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h6000_0400, 32'h6000_0008, 2'd1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h6000_0400, 32'h6000_0008, 2'd1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h6000_0400, 32'h6000_0008, 2'd1));
    // both ports plus prediction plus fire: port 0 wins, pc_prev still updates
    vecs.push_back(mk(1'b0, 2'b11, 32'h6000_0800, 32'h6000_0900, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h6000_0800, 32'h6000_0400, 2'd2));
    // taken prediction, low bits cleared
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h6000_0013, 1'b0, 1'b1, 1'b1, 32'h6000_0010, 32'h6000_0800, 2'd2));
    // halt with fire: pc still advances, then HALTED
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h6000_0014, 32'h6000_0010, 2'd2));
    // prediction ignored in HALTED
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h7000_0000, 1'b0, 1'b1, 1'b0, 32'h6000_0014, 32'h6000_0010, 2'd2));
    // redirect resumes (target low bits cleared)
    vecs.push_back(mk(1'b0, 2'b01, 32'h6000_0201, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h6000_0200, 32'h6000_0010, 2'd3));
    // epoch wraps 3 -> 0
    vecs.push_back(mk(1'b0, 2'b01, 32'h6000_0300, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h6000_0300, 32'h6000_0010, 2'd0));
    // redirect with halt: stays RUN
    vecs.push_back(mk(1'b0, 2'b10, 32'h0,         32'h6000_0304, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h6000_0304, 32'h6000_0300, 2'd1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h6000_0308, 32'h6000_0304, 2'd1));
    // reset mid-operation
    vecs.push_back(mk(1'b1, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h6000_0000, 32'h6000_0000, 2'd0));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h6000_0000, 32'h6000_0000, 2'd0));
    // address wrap-around
    vecs.push_back(mk(1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h6000_0000, 2'd1));
    vecs.push_back(mk(1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 2'd1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc0, vecs[i].rpc1, vecs[i].pv, vecs[i].ppc,
            vecs[i].halt, vecs[i].ready);
      tick();
      check($sformatf("vec%0d valid", i), {31'd0, if1.req_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d pc", i), if1.req_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d pc_prev", i), pc_prev1, vecs[i].exp_prev);
      check($sformatf("vec%0d epoch", i), {30'd0, if1.req_epoch}, {30'd0, vecs[i].exp_epoch});
      check($sformatf("vec%0d mask1", i), {31'd0, if1.req_slot_mask}, 32'd1);
    end

    // Width-4 group alignment and slot masks.
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("w4 reset valid", {31'd0, if4.req_valid}, 32'd0);
    check("w4 reset mask", {28'd0, if4.req_slot_mask}, 32'hF);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("w4 boot->run", {31'd0, if4.req_valid}, 32'd1);
    drive(1'b0, 2'b01, 32'h6000_0108, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("w4 redir pc", if4.req_pc, 32'h6000_0108);
    check("w4 redir mask", {28'd0, if4.req_slot_mask}, 32'hC);
    check("w4 redir epoch", {30'd0, if4.req_epoch}, 32'd1);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check("w4 seq1 pc", if4.req_pc, 32'h6000_0110);
    check("w4 seq1 mask", {28'd0, if4.req_slot_mask}, 32'hF);
    check("w4 seq1 prev", pc_prev4, 32'h6000_0108);
    tick();
    check("w4 seq2 pc", if4.req_pc, 32'h6000_0120);
    check("w4 seq2 prev", pc_prev4, 32'h6000_0110);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h6000_0206, 1'b0, 1'b1);
    tick();
    check("w4 pred pc", if4.req_pc, 32'h6000_0204);
    check("w4 pred mask", {28'd0, if4.req_slot_mask}, 32'hE);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check("w4 realign pc", if4.req_pc, 32'h6000_0210);
    check("w4 realign prev", pc_prev4, 32'h6000_0204);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("w4 stall pc", if4.req_pc, 32'h6000_0210);
    check("w4 stall mask", {28'd0, if4.req_slot_mask}, 32'hF);

    // Five back-to-back redirects from a fresh reset walk the epoch 1,2,3,0,1; reset restarts it.
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    begin
      logic [1:0] exp_ep [5];
      exp_ep = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int k = 0; k < 5; k++) begin
        drive(1'b0, 2'b01, 32'h6000_1000 + 32'(k * 4), 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check($sformatf("wrap%0d epoch w1", k), {30'd0, if1.req_epoch}, {30'd0, exp_ep[k]});
        check($sformatf("wrap%0d epoch w4", k), {30'd0, if4.req_epoch}, {30'd0, exp_ep[k]});
        check($sformatf("wrap%0d pc", k), if1.req_pc, 32'h6000_1000 + 32'(k * 4));
      end
    end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("post-reset epoch", {30'd0, if1.req_epoch}, 32'd0);
    check("post-reset pc", if1.req_pc, 32'h6000_0000);
    check("post-reset valid", {31'd0, if1.req_valid}, 32'd0);
    check("post-reset epoch w4", {30'd0, if4.req_epoch}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
